// File: rtl/keyboard_scancode_decoder.sv
// ---------------------------------------------------------------------------
// keyboard_scancode_decoder
//
// Turns a stream of PS/2 set-2 scan-code bytes into key events and queues
// them in a small FIFO. Prefix bytes (E0 extended, F0 break, E1 pause) are
// folded into the event; keyboard status/response bytes are discarded.
//
// Parameters
//   FIFO_DEPTH   key-event FIFO depth (power of two, >= 2)
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low reset
//   byte_in      scan-code byte from the serial-to-parallel stage
//   byte_valid   one-cycle strobe qualifying byte_in
//   event_ready  consumer accepts the head event
//   event_valid  FIFO non-empty, head event presented
//   event_code   key code of the head event (0 when event_valid=0)
//   event_ext    head event carried an E0 prefix (0 when event_valid=0)
//   event_break  head event is a key release (0 when event_valid=0)
//   overflow     one-cycle pulse after a completed event was dropped (FIFO full)
// ---------------------------------------------------------------------------
module keyboard_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       event_ready,
    output logic       event_valid,
    output logic [7:0] event_code,
    output logic       event_ext,
    output logic       event_break,
    output logic       overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_PAUSE   = 3'd4;

    // Status / response bytes the keyboard can interleave with scan codes.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
               (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // -----------------------------------------------------------------------
    // Decoder
    // -----------------------------------------------------------------------
    logic [2:0] state_reg, state_next;
    logic [2:0] skip_reg, skip_next;
    logic       armed_reg;
    logic       take;
    logic       push_req;
    logic [7:0] push_code;
    logic       push_ext;
    logic       push_brk;

    // armed_reg stays low through the first rising edge after reset release,
    // so a strobe that happens to be high at release is not taken.
    assign take = byte_valid && armed_reg;

    always_comb begin
        state_next = state_reg;
        skip_next  = skip_reg;
        push_req   = 1'b0;
        push_code  = byte_in;
        push_ext   = 1'b0;
        push_brk   = 1'b0;
        if (take) begin
            case (state_reg)
                ST_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_next = ST_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_next = ST_BRK;
                    end else if (byte_in == 8'hE1) begin
                        state_next = ST_PAUSE;
                        skip_next  = 3'd7;
                    end else if (!is_discard(byte_in)) begin
                        push_req = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (byte_in == 8'hF0) begin
                        state_next = ST_EXT_BRK;
                    end else if (byte_in == 8'hE0) begin
                        state_next = ST_EXT;
                    end else begin
                        // E0 12 is the fake-shift wrapper around some
                        // extended keys; it carries no key event.
                        state_next = ST_IDLE;
                        if (byte_in != 8'h12 && byte_in != 8'hE1 && !is_discard(byte_in)) begin
                            push_req = 1'b1;
                            push_ext = 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    state_next = ST_IDLE;
                    if (byte_in != 8'hE0 && byte_in != 8'hE1 && byte_in != 8'hF0 &&
                        !is_discard(byte_in)) begin
                        push_req = 1'b1;
                        push_brk = 1'b1;
                    end
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    if (byte_in != 8'h12 && byte_in != 8'hE0 && byte_in != 8'hE1 &&
                        byte_in != 8'hF0 && !is_discard(byte_in)) begin
                        push_req = 1'b1;
                        push_ext = 1'b1;
                        push_brk = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // Pause/Break sends a fixed 8-byte burst with no break
                    // code; swallow the tail and report it as a single E1.
                    skip_next = skip_reg - 3'd1;
                    if (skip_reg <= 3'd1) begin
                        skip_next  = 3'd0;
                        state_next = ST_IDLE;
                        push_req   = 1'b1;
                        push_code  = 8'hE1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    skip_next  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            skip_reg  <= 3'd0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            skip_reg  <= skip_next;
            armed_reg <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Event FIFO
    // -----------------------------------------------------------------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             overflow_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic [9:0]       head_word;

    assign full        = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
    assign event_valid = (count_reg != '0);
    assign do_pop      = event_valid && event_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign do_push     = push_req && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (PTR_W + 1)'(1);
            2'b01:   count_next = count_reg - (PTR_W + 1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            overflow_reg <= push_req && full && !do_pop;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= {push_ext, push_brk, push_code};
        end
    end

    assign head_word   = mem[rd_ptr_reg];
    assign event_code  = event_valid ? head_word[7:0] : 8'h00;
    assign event_break = event_valid ? head_word[8]   : 1'b0;
    assign event_ext   = event_valid ? head_word[9]   : 1'b0;
    assign overflow    = overflow_reg;

endmodule

// File: doc/keyboard_scancode_decoder.md
KEYBOARD_SCANCODE_DECODER -- requirements
Module: keyboard_scancode_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, key-event FIFO depth; power of two, >= 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 byte_in  input  8  scan-code byte from the keyboard serial-to-parallel stage.
REQ-005 byte_valid  input  1  one-cycle strobe; byte_in is valid in this cycle.
REQ-006 event_ready  input  1  consumer accepts the head event.
REQ-007 event_valid  output  1  FIFO non-empty; head event presented.
REQ-008 event_code  output  8  key code of the head event.
REQ-009 event_ext  output  1  head event had an E0 prefix.
REQ-010 event_break  output  1  head event is a key release (F0 prefix).
REQ-011 overflow  output  1  one-cycle pulse when a completed event is dropped because the FIFO is full.

Function
REQ-012 A byte is consumed only in a cycle with byte_valid=1; byte_in is ignored otherwise.
REQ-013 Decoder states SHALL be IDLE, EXT, BRK, EXT_BRK and PAUSE.
REQ-014 IDLE transitions: E0->EXT; F0->BRK; E1->PAUSE with skip counter=7; 00, AA, FA, FC, FE, FF->discard, stay IDLE; any other byte->push {code, ext=0, brk=0}, stay IDLE.
REQ-015 EXT transitions: F0->EXT_BRK; E0->stay EXT; 12->discard, go IDLE; E1 or any listed discard byte->discard, go IDLE; any other byte->push {code, 1, 0}, go IDLE.
REQ-016 BRK transitions: E0, E1, F0 or any listed discard byte->discard, go IDLE; any other byte->push {code, 0, 1}, go IDLE.
REQ-017 EXT_BRK transitions: 12->discard, go IDLE; E0, E1, F0 or any listed discard byte->discard, go IDLE; any other byte->push {code, 1, 1}, go IDLE.
REQ-018 PAUSE: each consumed byte decrements the 3-bit skip counter regardless of value; the byte that brings it to 0 pushes {E1, 0, 0} and returns to IDLE.
REQ-019 A push occurs on the same rising edge that samples the completing byte; event_valid is 1 in the following cycle when the FIFO was empty (1-cycle latency).
REQ-020 Pop occurs on a rising edge with event_valid=1 and event_ready=1.
REQ-021 Head outputs SHALL hold stable while event_valid=1 and event_ready=0.
REQ-022 Events leave the FIFO in push order; pointers wrap modulo FIFO_DEPTH; the occupancy count is one bit wider than the pointers.
REQ-023 Full with no pop: the push is dropped, FIFO contents are unchanged, and overflow=1 for exactly that cycle; the decoder still takes its normal transition.
REQ-024 Full with a simultaneous pop: both occur, occupancy stays at FIFO_DEPTH, and overflow stays 0.
REQ-025 Empty with a simultaneous push: the push occurs; event_ready has no effect that cycle.
REQ-026 event_code, event_ext and event_break SHALL be 0 whenever event_valid=0.

Reset
REQ-027 When reset=0, the block immediately clears decoder state to IDLE, the skip counter to 0, FIFO pointers and count to 0, and drives event_valid=0, event_code=0, event_ext=0, event_break=0, overflow=0.
REQ-028 Reset asserted mid-sequence (in EXT, BRK, EXT_BRK or PAUSE) abandons the partial sequence; no event is emitted for it after release.
REQ-029 byte_valid is ignored while reset=0 and in the first rising edge after release.

Verification
REQ-030 Bytes 1C, then F0 1C, with event_ready=1 -> events {1C,0,0} then {1C,0,1}, each event_valid for one cycle.
REQ-031 Bytes E0 75, then E0 F0 75 -> events {75,1,0} then {75,1,1}; bytes E0 12 and E0 F0 12 -> no event.
REQ-032 Bytes E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}, emitted after the eighth byte.
REQ-033 FIFO_DEPTH=4 with event_ready=0 and 5 make codes -> first 4 events retained in order, overflow pulses once on the fifth; a pop in the same cycle as a push while full -> no overflow.
REQ-034 Reset asserted after E0 F0, then released, then byte 1C -> single event {1C,0,0}; all outputs 0 during reset.
REQ-035 Bytes AA, FA, F0 E0 -> no event, decoder returns to IDLE; a following 1C -> {1C,0,0}.
